// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and the
// default sequencing constants used by the RTL and its testbench.
package reset_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } seq_state_t;

    // Default sequencing constants.
    localparam int DEF_N_STAGES    = 3;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/reset_sequencer.sv
// Reset sequencer: after the synchronized reset deasserts, holds all reset
// domains for HOLD_CYCLES, then releases them one at a time (bit 0 first)
// every GAP_CYCLES and finally flags o_ready. A soft request restarts it.
// Every output is a flop output so downstream resets are glitch-free.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_soft_req,
    output logic [N_STAGES-1:0] o_rst,
    output logic                o_ready
);

    localparam int IDX_W = $clog2(N_STAGES + 1);

    // Counter values seen on the edge that ends a hold or gap interval.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);

    if (N_STAGES < 1) begin : g_bad_stages
        $error("reset_sequencer: N_STAGES must be at least 1");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be in 1 .. 2**CNT_W-1");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_gap
        $error("reset_sequencer: GAP_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    seq_state_t          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [N_STAGES-1:0] rst_d;
    logic                ready_d;
    logic [N_STAGES-1:0] release_next;

    // One-hot mask selecting the stage addressed by the release index.
    function automatic logic [N_STAGES-1:0] stage_bit(input logic [IDX_W-1:0] k);
        logic [N_STAGES-1:0] mask;
        mask = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (k == IDX_W'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Releasing ORs in the next stage, so o_rst only ever grows as 0..01..1.
    always_comb begin
        release_next = o_rst | stage_bit(idx);
    end

    // Next-state logic; a soft request overrides every transition.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rst_d   = o_rst;
        ready_d = o_ready;

        if (i_soft_req) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        rst_d   = release_next;
                        cnt_d   = '0;
                        idx_d   = idx + IDX_ONE;
                        state_d = (N_STAGES == 1) ? S_RUN : S_RELEASE;
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        rst_d = release_next;
                        cnt_d = '0;
                        idx_d = idx + IDX_ONE;
                        if (idx == LAST_IDX) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    // Unused encoding: restart the whole sequence safely.
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, counters and outputs; async reset asserts every domain at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_HOLD;
            cnt     <= '0;
            idx     <= '0;
            o_rst   <= '0;
            o_ready <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            o_rst   <= rst_d;
            o_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default three-stage instance and a minimal
// single-stage instance, checked every edge against a model that counts
// edges since the last restart and derives the released stages from that.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       soft_a;
    logic       soft_b;
    logic [2:0] rst_a;
    logic       ready_a;
    logic [0:0] rst_b;
    logic       ready_b;

    int vectors     = 0;
    int miscompares = 0;
    int na          = 0;
    int nb          = 0;

    reset_sequencer dut_a (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_soft_req (soft_a),
        .o_rst      (rst_a),
        .o_ready    (ready_a)
    );

    reset_sequencer #(
        .N_STAGES    (1),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1)
    ) dut_b (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_soft_req (soft_b),
        .o_rst      (rst_b),
        .o_ready    (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stages whose release time n >= h + k*g has passed.
    function automatic logic [2:0] exp_rst(input int n, input int ns, input int h, input int g);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 0; k < ns; k++) begin
            if (n >= h + k * g) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic exp_ready(input int n, input int ns, input int h, input int g);
        return n >= h + (ns - 1) * g + 1;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_rst",   rst_a,              exp_rst(na, DEF_N_STAGES, DEF_HOLD_CYCLES, DEF_GAP_CYCLES));
        check("a_ready", {2'b00, ready_a},   {2'b00, exp_ready(na, DEF_N_STAGES, DEF_HOLD_CYCLES, DEF_GAP_CYCLES)});
        check("b_rst",   {2'b00, rst_b[0]},  exp_rst(nb, 1, 1, 1));
        check("b_ready", {2'b00, ready_b},   {2'b00, exp_ready(nb, 1, 1, 1)});
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            na = 0;
            nb = 0;
        end else begin
            na = soft_a ? 0 : ((na < 10000) ? na + 1 : na);
            nb = soft_b ? 0 : ((nb < 10000) ? nb + 1 : nb);
        end
        check_all();
    endtask

    initial begin
        rst_n  = 1'b1;
        soft_a = 1'b0;
        soft_b = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all();

        // Power-on reset for 5 edges, then the full default sequence.
        for (int e = 0; e < 5; e++) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            soft_b = (e == 5);
            tick();
            if (e == 15) check("por_e15", rst_a, 3'b000);
            if (e == 16) check("por_e16", rst_a, 3'b001);
            if (e == 20) check("por_e20", rst_a, 3'b011);
            if (e == 24) check("por_e24", rst_a, 3'b111);
            if (e == 24) check("por_rdy24", {2'b00, ready_a}, 3'b000);
            if (e == 25) check("por_rdy25", {2'b00, ready_a}, 3'b001);
            if (e == 5)  check("b_soft_e5", {2'b00, rst_b[0]}, 3'b000);
            if (e == 6)  check("b_soft_e6", {2'b00, rst_b[0]}, 3'b001);
        end
        soft_b = 1'b0;

        // Soft request for one edge while running.
        soft_a = 1'b1;
        tick();
        check("soft_e0", rst_a, 3'b000);
        soft_a = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            tick();
            if (e == 16) check("soft_e16", rst_a, 3'b001);
            if (e == 24) check("soft_e24", rst_a, 3'b111);
            if (e == 25) check("soft_rdy25", {2'b00, ready_a}, 3'b001);
        end

        // Restart via async reset, then drop it between edges 21 and 22.
        rst_n = 1'b0;
        #1;
        na = 0;
        nb = 0;
        rst_n = 1'b1;
        for (int e = 1; e <= 21; e++) tick();
        check("mid_e21", rst_a, 3'b011);
        rst_n = 1'b0;
        #1;
        check("async_rst", rst_a, 3'b000);
        check("async_rdy", {2'b00, ready_b}, 3'b000);
        na = 0;
        nb = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 16) check("rerun_e16", rst_a, 3'b001);
        end

        // Soft request held for 40 edges.
        soft_a = 1'b1;
        for (int e = 0; e < 40; e++) tick();
        soft_a = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 15) check("held_e15", rst_a, 3'b000);
            if (e == 16) check("held_e16", rst_a, 3'b001);
        end

        // Soft request on the HOLD->RELEASE edge.
        soft_a = 1'b1;
        tick();
        soft_a = 1'b0;
        for (int e = 1; e <= 15; e++) tick();
        soft_a = 1'b1;
        tick();
        check("collide_e16", rst_a, 3'b000);
        soft_a = 1'b0;
        for (int e = 17; e <= 33; e++) begin
            tick();
            if (e == 31) check("collide_e31", rst_a, 3'b000);
            if (e == 32) check("collide_e32", rst_a, 3'b001);
        end

        // Randomized soft requests and occasional async reset pulses.
        for (int i = 0; i < 600; i++) begin
            soft_a = ($urandom_range(0, 29) == 0);
            soft_b = ($urandom_range(0, 4) == 0);
            tick();
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                #1;
                na = 0;
                nb = 0;
                check_all();
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
